stream_resize: RTL and testbench



---
 rtl/stream_resize.sv | 184 ++++++++++++++++++
 tb/tb_stream_resize.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_resize.sv
// stream_resize: power-of-two stream width converter (pack, unpack or pass by parameters).
// Define STREAM_RESIZE_FLUSH_EN to flush a partial pack word on done instead of discarding it.
module stream_resize #(
  parameter int unsigned IN_LEN  = 2,
  parameter int unsigned OUT_LEN = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inclk,
  input  logic [IN_LEN-1:0]  in,
  input  logic               done_in,
  output logic               in_rdy,
  input  logic               out_rdy,
  output logic               outclk,
  output logic [OUT_LEN-1:0] out,
  output logic               done_out,
  output logic               idle,
  output logic               ovf
);

  localparam int unsigned MaxLen   = (IN_LEN > OUT_LEN) ? IN_LEN : OUT_LEN;
  localparam int unsigned MinLen   = (IN_LEN > OUT_LEN) ? OUT_LEN : IN_LEN;
  localparam int unsigned R        = (MinLen == 0) ? 0 : MaxLen / MinLen;
  localparam bit          Divides  = (MinLen == 0) ? 1'b0 : ((MaxLen % MinLen) == 0);
  localparam bit          Legal    = Divides && (R != 0) && ((R & (R - 1)) == 0);
  localparam bit          PackMode = IN_LEN <= OUT_LEN;

  if (!Legal) begin : g_bad_param
    $error("stream_resize: IN_LEN/OUT_LEN ratio must be a power of two");
  end

  logic               accept;
  logic               emit;
  logic               empty;
  logic               fire;
  logic [OUT_LEN-1:0] emit_word;

  logic               done_found_q, done_found_d;
  logic               outclk_q, outclk_d;
  logic [OUT_LEN-1:0] out_q, out_d;
  logic               done_out_q, done_out_d;
  logic               ovf_q, ovf_d;

  assign accept = inclk & in_rdy;
  assign fire   = done_found_q & empty;

  if (PackMode) begin : g_pack
    localparam int unsigned CntW   = (R > 1) ? $clog2(R) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(R - 1);

    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [OUT_LEN-1:0] acc_q, acc_d;
    logic [OUT_LEN-1:0] hold_q, hold_d;
    logic               pend_q, pend_d;
    logic               flush;
    logic               drop;

`ifdef STREAM_RESIZE_FLUSH_EN
    assign flush = done_found_q && (cnt_q != '0) && !pend_q;
    assign drop  = 1'b0;
`else
    assign flush = 1'b0;
    assign drop  = done_in;
`endif

    assign in_rdy    = !pend_q || (cnt_q != CntMax);
    assign emit      = pend_q && out_rdy;
    assign emit_word = hold_q;
    assign empty     = (cnt_q == '0) && !pend_q;

    always_comb begin
      cnt_d  = cnt_q;
      acc_d  = acc_q;
      hold_d = hold_q;
      pend_d = pend_q;
      if (emit) pend_d = 1'b0;
      // Flush first so a slice accepted in the same cycle starts the next word.
      if (flush) begin
        hold_d = acc_q;
        pend_d = 1'b1;
        acc_d  = '0;
        cnt_d  = '0;
      end
      if (accept) begin
        acc_d = acc_d | (OUT_LEN'(in) << (cnt_d * IN_LEN));
        if (cnt_d == CntMax) begin
          hold_d = acc_d;
          pend_d = 1'b1;
          acc_d  = '0;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_d + 1'b1;
        end
      end
      if (drop) begin
        acc_d = '0;
        cnt_d = '0;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q  <= '0;
        acc_q  <= '0;
        hold_q <= '0;
        pend_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        acc_q  <= acc_d;
        hold_q <= hold_d;
        pend_q <= pend_d;
      end
    end
  end else begin : g_unpack
    localparam int unsigned RemW = $clog2(R + 1);
    localparam logic [RemW-1:0] RemFull = RemW'(R);

    logic [RemW-1:0]   rem_q, rem_d;
    logic [IN_LEN-1:0] shift_q, shift_d;

    // Ready while the last slice drains, so a new word loads on the same edge.
    assign in_rdy    = (rem_q == '0) || ((rem_q == RemW'(1)) && out_rdy);
    assign emit      = (rem_q != '0) && out_rdy;
    assign emit_word = shift_q[OUT_LEN-1:0];
    assign empty     = rem_q == '0;

    always_comb begin
      rem_d   = rem_q;
      shift_d = shift_q;
      if (emit) begin
        shift_d = shift_q >> OUT_LEN;
        rem_d   = rem_q - 1'b1;
      end
      if (accept) begin
        shift_d = in;
        rem_d   = RemFull;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rem_q   <= '0;
        shift_q <= '0;
      end else begin
        rem_q   <= rem_d;
        shift_q <= shift_d;
      end
    end
  end

  always_comb begin
    outclk_d     = emit;
    out_d        = emit ? emit_word : out_q;
    done_out_d   = fire;
    ovf_d        = ovf_q | (inclk & ~in_rdy);
    done_found_d = done_found_q;
    // A done_in arriving while one is pending merges into it.
    if (fire)         done_found_d = 1'b0;
    else if (done_in) done_found_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outclk_q     <= 1'b0;
      out_q        <= '0;
      done_out_q   <= 1'b0;
      ovf_q        <= 1'b0;
      done_found_q <= 1'b0;
    end else begin
      outclk_q     <= outclk_d;
      out_q        <= out_d;
      done_out_q   <= done_out_d;
      ovf_q        <= ovf_d;
      done_found_q <= done_found_d;
    end
  end

  assign outclk   = outclk_q;
  assign out      = out_q;
  assign done_out = done_out_q;
  assign ovf      = ovf_q;
  assign idle     = empty & ~done_found_q;

endmodule

// File: tb/tb_stream_resize.sv
// Bench for stream_resize: pack 2->8, unpack 8->2 and pass 8->8 instances checked against
// queue-based word models plus hand-computed directed expectations.
module tb_stream_resize;

`ifdef STREAM_RESIZE_FLUSH_EN
  localparam bit FlushEn = 1'b1;
`else
  localparam bit FlushEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic bad(input string name, input logic [31:0] act);
    nvec++;
    nerr++;
    $display("FAIL %s: got word %0h, required no output", name, act);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pack 2 -> 8
  logic       p_inclk = 1'b0, p_done_in = 1'b0, p_out_rdy = 1'b1;
  logic [1:0] p_in = '0;
  logic       p_in_rdy, p_outclk, p_done_out, p_idle, p_ovf;
  logic [7:0] p_out;
  stream_resize #(.IN_LEN(2), .OUT_LEN(8)) u_pack (
    .clk(clk), .rst(rst), .inclk(p_inclk), .in(p_in), .done_in(p_done_in), .in_rdy(p_in_rdy),
    .out_rdy(p_out_rdy), .outclk(p_outclk), .out(p_out), .done_out(p_done_out),
    .idle(p_idle), .ovf(p_ovf)
  );

  // Unpack 8 -> 2
  logic       u_inclk = 1'b0, u_done_in = 1'b0, u_out_rdy = 1'b1;
  logic [7:0] u_in = '0;
  logic       u_in_rdy, u_outclk, u_done_out, u_idle, u_ovf;
  logic [1:0] u_out;
  stream_resize #(.IN_LEN(8), .OUT_LEN(2)) u_unp (
    .clk(clk), .rst(rst), .inclk(u_inclk), .in(u_in), .done_in(u_done_in), .in_rdy(u_in_rdy),
    .out_rdy(u_out_rdy), .outclk(u_outclk), .out(u_out), .done_out(u_done_out),
    .idle(u_idle), .ovf(u_ovf)
  );

  // Pass 8 -> 8
  logic       s_inclk = 1'b0, s_done_in = 1'b0, s_out_rdy = 1'b0;
  logic [7:0] s_in = '0;
  logic       s_in_rdy, s_outclk, s_done_out, s_idle, s_ovf;
  logic [7:0] s_out;
  stream_resize #(.IN_LEN(8), .OUT_LEN(8)) u_pass (
    .clk(clk), .rst(rst), .inclk(s_inclk), .in(s_in), .done_in(s_done_in), .in_rdy(s_in_rdy),
    .out_rdy(s_out_rdy), .outclk(s_outclk), .out(s_out), .done_out(s_done_out),
    .idle(s_idle), .ovf(s_ovf)
  );

  // Word-level models: accepted input is turned into the expected output word sequence.
  logic [7:0] p_exp[$];
  logic [1:0] u_exp[$];
  logic [7:0] s_exp[$];
  logic [7:0] p_acc = '0, p_last = '0, s_last = '0;
  logic [1:0] u_last = '0;
  int p_cnt = 0, p_nout = 0, p_ndone = 0, u_nout = 0, u_ndone = 0, s_nout = 0;
  bit p_dpend = 0, u_dpend = 0, s_dpend = 0;
  bit p_rdy_prev = 0, u_rdy_prev = 0, s_rdy_prev = 0;

  always @(negedge clk) begin
    if (rst) begin
      p_exp.delete(); u_exp.delete(); s_exp.delete();
      p_acc = '0; p_cnt = 0; p_last = '0; u_last = '0; s_last = '0;
      p_dpend = 0; u_dpend = 0; s_dpend = 0;
    end else begin
      // pack
      if (p_outclk) begin
        p_nout++;
        chk("pack_stall", p_rdy_prev, 1);
        if (p_exp.size() == 0) bad("pack_extra", p_out);
        else chk("pack_word", p_out, p_exp.pop_front());
        p_last = p_out;
      end else chk("pack_hold", p_out, p_last);
      if (p_done_out) begin
        p_ndone++;
        chk("pack_done", {p_dpend, p_exp.size() == 0, p_outclk}, 3'b110);
        p_dpend = 0;
      end
      if (p_inclk && p_in_rdy) begin
        p_acc = p_acc | (8'(p_in) << (2 * p_cnt));
        p_cnt++;
        if (p_cnt == 4) begin
          p_exp.push_back(p_acc);
          p_acc = '0;
          p_cnt = 0;
        end
      end
      if (p_done_in) begin
        if (FlushEn && p_cnt != 0) p_exp.push_back(p_acc);
        p_acc = '0;
        p_cnt = 0;
        p_dpend = 1;
      end
      // unpack
      if (u_outclk) begin
        u_nout++;
        chk("unp_stall", u_rdy_prev, 1);
        if (u_exp.size() == 0) bad("unp_extra", u_out);
        else chk("unp_word", u_out, u_exp.pop_front());
        u_last = u_out;
      end else chk("unp_hold", u_out, u_last);
      if (u_done_out) begin
        u_ndone++;
        chk("unp_done", {u_dpend, u_exp.size() == 0, u_outclk}, 3'b110);
        u_dpend = 0;
      end
      if (u_inclk && u_in_rdy)
        for (int k = 0; k < 4; k++) u_exp.push_back(2'(u_in >> (2 * k)));
      if (u_done_in) u_dpend = 1;
      // pass
      if (s_outclk) begin
        s_nout++;
        chk("pass_stall", s_rdy_prev, 1);
        if (s_exp.size() == 0) bad("pass_extra", s_out);
        else chk("pass_word_m", s_out, s_exp.pop_front());
        s_last = s_out;
      end else chk("pass_hold", s_out, s_last);
      if (s_done_out) begin
        chk("pass_done", {s_dpend, s_exp.size() == 0, s_outclk}, 3'b110);
        s_dpend = 0;
      end
      if (s_inclk && s_in_rdy) s_exp.push_back(s_in);
      if (s_done_in) s_dpend = 1;
    end
    p_rdy_prev = p_out_rdy;
    u_rdy_prev = u_out_rdy;
    s_rdy_prev = s_out_rdy;
  end

  initial begin
    logic [1:0] ps[8];
    logic [1:0] ud[8];
    int n0, d0;
    ps = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd3, 2'd0, 2'd1, 2'd2};
    ud = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0};

    step(); step();
    chk("rst_outclk", p_outclk, 0);
    chk("rst_out", p_out, 8'h00);
    chk("rst_done_out", p_done_out, 0);
    chk("rst_ovf", p_ovf, 0);
    chk("rst_in_rdy", p_in_rdy, 1);
    chk("rst_idle", p_idle, 1);
    chk("rst_unp_rdy", u_in_rdy, 1);
    chk("rst_unp_idle", u_idle, 1);
    chk("rst_pass_idle", s_idle, 1);
    rst = 1'b0;
    step();

    // Pack: two back-to-back words, each out 2 cycles after its last slice.
    for (int c = 0; c < 11; c++) begin
      p_inclk = (c < 8);
      p_in = ps[c % 8];
      chk("pack_in_rdy", p_in_rdy, 1);
      chk("pack_outclk", p_outclk, (c == 5 || c == 9));
      if (c == 5) chk("pack_w0", p_out, 8'h39);
      if (c == 9) chk("pack_w1", p_out, 8'h93);
      step();
    end
    p_inclk = 1'b0;

    // Partial word then done: flushed as 3F or discarded.
    n0 = p_nout;
    d0 = p_ndone;
    for (int c = 0; c < 12; c++) begin
      p_inclk = (c < 3);
      p_in = 2'd3;
      p_done_in = (c == 3);
      step();
    end
    chk("flush_outs", p_nout - n0, FlushEn ? 1 : 0);
    chk("flush_done", p_ndone - d0, 1);
    chk("flush_word", p_out, FlushEn ? 8'h3F : 8'h93);
    chk("flush_idle", p_idle, 1);

    // Unpack: second word loads while the last slice drains.
    for (int c = 0; c < 11; c++) begin
      u_inclk = (c == 0 || c == 4);
      u_in = (c == 4) ? 8'h1B : 8'hB4;
      #1;
      if (c == 3) chk("unp_rdy3", u_in_rdy, 0);
      if (c == 4) chk("unp_rdy4", u_in_rdy, 1);
      chk("unp_outclk", u_outclk, (c >= 2 && c <= 9));
      if (c >= 2 && c <= 9) chk("unp_dibit", u_out, ud[c - 2]);
      step();
    end
    chk("unp_ovf", u_ovf, 0);

    // Backpressure with done riding on the only input word.
    d0 = u_ndone;
    for (int c = 0; c < 11; c++) begin
      u_inclk = (c == 0);
      u_in = 8'hB4;
      u_done_in = (c == 0);
      u_out_rdy = !(c >= 3 && c <= 5);
      #1;
      chk("bp_outclk", u_outclk, (c == 2 || c == 3 || c == 7 || c == 8));
      if (c >= 3 && c <= 6) chk("bp_hold", u_out, 2'd1);
      if (c == 7) chk("bp_resume0", u_out, 2'd3);
      if (c == 8) chk("bp_resume1", u_out, 2'd2);
      chk("bp_done", u_done_out, (c == 9));
      step();
    end
    chk("bp_done_cnt", u_ndone - d0, 1);

    // Pass overflow: BB dropped while AA waits for out_rdy.
    n0 = s_nout;
    for (int c = 0; c < 6; c++) begin
      s_inclk = (c < 2);
      s_in = (c == 0) ? 8'hAA : 8'hBB;
      s_out_rdy = (c >= 2);
      #1;
      if (c == 1) chk("pass_rdy", s_in_rdy, 0);
      chk("pass_ovf", s_ovf, (c >= 2));
      chk("pass_outclk", s_outclk, (c == 3));
      if (c >= 3) chk("pass_word", s_out, 8'hAA);
      step();
    end
    s_inclk = 1'b0;
    chk("pass_count", s_nout - n0, 1);

    // Asynchronous reset in the middle of an unpack.
    u_out_rdy = 1'b1;
    u_inclk = 1'b1;
    u_in = 8'h5A;
    step();
    u_in = 8'hFF;
    step();
    u_inclk = 1'b0;
    chk("mid_outclk", u_outclk, 1);
    chk("mid_out", u_out, 2'd2);
    chk("mid_ovf", u_ovf, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_outclk", u_outclk, 0);
    chk("arst_out", u_out, 2'd0);
    chk("arst_done_out", u_done_out, 0);
    chk("arst_ovf", u_ovf, 0);
    chk("arst_idle", u_idle, 1);
    chk("arst_in_rdy", u_in_rdy, 1);
    chk("arst_pass_ovf", s_ovf, 0);
    step();
    rst = 1'b0;
    n0 = u_nout;
    repeat (6) step();
    chk("arst_no_out", u_nout - n0, 0);
    chk("arst_idle_after", u_idle, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
